// File: rtl/proc_run_ctrl.sv
// Run-control sequencer: debounces run/step buttons and turns them into a single-cycle
// processor clock enable, plus a display snapshot of the ALU result after each enable.
module proc_run_ctrl #(
    parameter int RUN_DIV   = 2**26,
    parameter int DB_CYCLES = 2**20,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_step,
    input  logic [DATA_W-1:0] result_in,
    output logic              proc_en,
    output logic              running,
    output logic [DATA_W-1:0] display_data,
    output logic [15:0]       step_count
);

    localparam int TICK_W = $clog2(RUN_DIV);
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    // Bit 0 carries the run button, bit 1 the step button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] db_q, db_d;
    logic [1:0] press_q, press_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    logic [1:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              proc_en_q, proc_en_d;
    logic              en_d_q, en_d_d;
    logic [DATA_W-1:0] display_q, display_d;
    logic [15:0]       step_count_q, step_count_d;

    logic run_p;
    logic step_p;

    assign btn_raw = {btn_step, btn_run};
    assign run_p   = press_q[0];
    assign step_p  = press_q[1];

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = ~db_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        press_d = db_d & ~db_q;
    end

    // The enable is decoded from the next state so it comes straight out of a flop.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        case (state_q)
            ST_HALT: begin
                if (run_p) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end else if (step_p) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_RUN: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                if (run_p) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
        proc_en_d = (state_d == ST_STEP) || ((state_d == ST_RUN) && (tick_d == TICK_LAST));
    end

    always_comb begin
        en_d_d       = proc_en_q;
        display_d    = en_d_q ? result_in : display_q;
        step_count_d = step_count_q + 16'(proc_en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            press_q      <= '0;
            db_cnt_q     <= '0;
            state_q      <= ST_HALT;
            tick_q       <= '0;
            proc_en_q    <= 1'b0;
            en_d_q       <= 1'b0;
            display_q    <= '0;
            step_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            press_q      <= press_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            proc_en_q    <= proc_en_d;
            en_d_q       <= en_d_d;
            display_q    <= display_d;
            step_count_q <= step_count_d;
        end
    end

    assign proc_en      = proc_en_q;
    assign running      = (state_q == ST_RUN);
    assign display_data = display_q;
    assign step_count   = step_count_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed segment table, hand-written reset sequences and
// randomized button activity, all checked cycle by cycle against a behavioural model.
module tb_proc_run_ctrl;

    localparam int RUN_DIV   = 4;
    localparam int DB_CYCLES = 3;
    localparam int DATA_W    = 16;

    localparam int MODE_HALT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_STEP = 2;

    typedef struct {
        bit          btnRun;
        bit          btnStep;
        logic [15:0] result;
        int          cycles;
        bit          expRunning;
        logic [15:0] expCount;
        logic [15:0] expDisplay;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              btnRun = 1'b0;
    logic              btnStep = 1'b0;
    logic [DATA_W-1:0] resultIn = '0;
    logic              procEn;
    logic              running;
    logic [DATA_W-1:0] displayData;
    logic [15:0]       stepCount;

    int passCount = 0;
    int checkCount = 0;

    // Model state: button history windows, a mode with an unbounded phase count,
    // and the enable/capture/counter outputs as the processor would observe them.
    bit          mValid = 1'b0;
    int          mMode = MODE_HALT;
    int          mPhase = 0;
    bit          mEn = 1'b0;
    bit          mEnD = 1'b0;
    logic [15:0] mCount = '0;
    logic [15:0] mDisp = '0;
    bit          mS1 [2];
    bit          mS2 [2];
    bit          mDb [2];
    bit          mPress [2];
    bit          mHist [2][DB_CYCLES];

    vec_t vecs [16];

    proc_run_ctrl #(
        .RUN_DIV  (RUN_DIV),
        .DB_CYCLES(DB_CYCLES),
        .DATA_W   (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_run     (btnRun),
        .btn_step    (btnStep),
        .result_in   (resultIn),
        .proc_en     (procEn),
        .running     (running),
        .display_data(displayData),
        .step_count  (stepCount)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit raw [2];
        int nextMode;
        int nextPhase;
        bit allDiff;
        raw[0] = btnRun;
        raw[1] = btnStep;
        if (reset) begin
            mValid = 1'b1;
            mMode  = MODE_HALT;
            mPhase = 0;
            mEn    = 1'b0;
            mEnD   = 1'b0;
            mCount = '0;
            mDisp  = '0;
            for (int i = 0; i < 2; i++) begin
                mS1[i] = 1'b0;
                mS2[i] = 1'b0;
                mDb[i] = 1'b0;
                mPress[i] = 1'b0;
                for (int j = 0; j < DB_CYCLES; j++) mHist[i][j] = 1'b0;
            end
        end else begin
            nextMode  = mMode;
            nextPhase = mPhase;
            case (mMode)
                MODE_HALT: begin
                    if (mPress[0]) begin
                        nextMode  = MODE_RUN;
                        nextPhase = 0;
                    end else if (mPress[1]) begin
                        nextMode = MODE_STEP;
                    end
                end
                MODE_STEP: nextMode = MODE_HALT;
                default: begin
                    if (mPress[0]) nextMode = MODE_HALT;
                    else nextPhase = mPhase + 1;
                end
            endcase
            mCount = mCount + 16'(mEn);
            if (mEnD) mDisp = resultIn;
            mEnD = mEn;
            mEn = (nextMode == MODE_STEP) ||
                  ((nextMode == MODE_RUN) && ((nextPhase % RUN_DIV) == RUN_DIV - 1));
            mMode  = nextMode;
            mPhase = nextPhase;
            // A level change is accepted once the last DB_CYCLES synchronized samples all disagree.
            for (int i = 0; i < 2; i++) begin
                for (int j = DB_CYCLES - 1; j > 0; j--) mHist[i][j] = mHist[i][j-1];
                mHist[i][0] = mS2[i];
                allDiff = 1'b1;
                for (int j = 0; j < DB_CYCLES; j++) begin
                    if (mHist[i][j] == mDb[i]) allDiff = 1'b0;
                end
                mPress[i] = allDiff && !mDb[i];
                if (allDiff) mDb[i] = !mDb[i];
                mS2[i] = mS1[i];
                mS1[i] = raw[i];
            end
        end
    endtask

    always @(posedge clk) modelStep();

    task automatic checkOutput();
        checkValue("model proc_en", 32'(procEn), 32'(mEn));
        checkValue("model running", 32'(running), 32'(mMode == MODE_RUN));
        checkValue("model step_count", 32'(stepCount), 32'(mCount));
        checkValue("model display_data", 32'(displayData), 32'(mDisp));
    endtask

    always @(negedge clk) begin
        if (mValid) checkOutput();
    end

    task automatic applyStimulus(input vec_t v);
        btnRun   = v.btnRun;
        btnStep  = v.btnStep;
        resultIn = v.result;
        repeat (v.cycles) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'hBEEF, 1,  1'b0, 16'd0,  16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'hBEEF, 1,  1'b0, 16'd0,  16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'hBEEF, 1,  1'b0, 16'd0,  16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 16'hBEEF, 1,  1'b0, 16'd0,  16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'hBEEF, 12, 1'b0, 16'd1,  16'hBEEF};
        vecs[5]  = '{1'b0, 1'b0, 16'h1111, 6,  1'b0, 16'd1,  16'hBEEF};
        vecs[6]  = '{1'b0, 1'b1, 16'h2222, 12, 1'b0, 16'd2,  16'h2222};
        vecs[7]  = '{1'b0, 1'b0, 16'h2222, 8,  1'b0, 16'd2,  16'h2222};
        vecs[8]  = '{1'b1, 1'b0, 16'h3333, 12, 1'b1, 16'd3,  16'h3333};
        vecs[9]  = '{1'b1, 1'b0, 16'h4444, 20, 1'b1, 16'd8,  16'h4444};
        vecs[10] = '{1'b1, 1'b1, 16'h5555, 8,  1'b1, 16'd10, 16'h5555};
        vecs[11] = '{1'b1, 1'b0, 16'h5555, 8,  1'b1, 16'd12, 16'h5555};
        vecs[12] = '{1'b0, 1'b0, 16'h6666, 8,  1'b1, 16'd14, 16'h6666};
        vecs[13] = '{1'b1, 1'b0, 16'h7777, 24, 1'b0, 16'd16, 16'h7777};
        vecs[14] = '{1'b0, 1'b0, 16'h8888, 8,  1'b0, 16'd16, 16'h7777};
        vecs[15] = '{1'b1, 1'b1, 16'h9999, 12, 1'b1, 16'd17, 16'h9999};

        // Reset with both buttons held, then release cleanly and confirm silence.
        reset   = 1'b1;
        btnRun  = 1'b1;
        btnStep = 1'b1;
        repeat (3) @(negedge clk);
        checkValue("reset proc_en", 32'(procEn), 32'd0);
        checkValue("reset running", 32'(running), 32'd0);
        checkValue("reset display_data", 32'(displayData), 32'd0);
        checkValue("reset step_count", 32'(stepCount), 32'd0);
        btnRun  = 1'b0;
        btnStep = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkValue("idle after reset proc_en", 32'(procEn), 32'd0);
        end

        // Segments are timed so run press in entry 13 lands on a terminal count.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkValue($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].expRunning));
            checkValue($sformatf("vec%0d step_count", i), 32'(stepCount), 32'(vecs[i].expCount));
            checkValue($sformatf("vec%0d display_data", i), 32'(displayData), 32'(vecs[i].expDisplay));
        end

        // Reset mid-RUN with the tick counter at 2 and seven pulses issued.
        reset   = 1'b1;
        btnRun  = 1'b0;
        btnStep = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        btnRun   = 1'b1;
        resultIn = 16'hA5A5;
        repeat (36) @(negedge clk);
        checkValue("pre-reset step_count", 32'(stepCount), 32'd7);
        checkValue("pre-reset running", 32'(running), 32'd1);
        reset  = 1'b1;
        btnRun = 1'b0;
        @(negedge clk);
        checkValue("mid-run reset running", 32'(running), 32'd0);
        checkValue("mid-run reset step_count", 32'(stepCount), 32'd0);
        checkValue("mid-run reset display_data", 32'(displayData), 32'd0);
        checkValue("mid-run reset proc_en", 32'(procEn), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkValue("post-reset proc_en", 32'(procEn), 32'd0);
        end

        // Random button activity with occasional resets, checked by the model each cycle.
        for (int s = 0; s < 150; s++) begin
            btnRun   = 1'($urandom_range(0, 1));
            btnStep  = 1'($urandom_range(0, 1));
            resultIn = 16'($urandom);
            reset    = ($urandom_range(0, 29) == 0);
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Run-control sequencer for the RISC_V core on the Basys3 board. It replaces the free-running processor clock tap with a single-cycle clock enable, `proc_en`, driven from the board clock. The enable follows one of two modes: free-run at a fixed divide rate, or single-step on a debounced button press. It also snapshots the core's ALU result after each executed instruction so the 7-segment display stays stable.

Parameters:
RUN_DIV, 2**26, board-clock cycles between `proc_en` pulses in RUN; legal range >= 2.
DB_CYCLES, 2**20, consecutive stable synchronized samples required to accept a button level change; legal range >= 2.
DATA_W, 16, width of `result_in` and `display_data`.

Ports:
clk  input  1  board clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
btn_run  input  1  raw, asynchronous run/halt toggle button.
btn_step  input  1  raw, asynchronous single-step button.
result_in  input  DATA_W  ALU result from the processor.
proc_en  output  1  one-cycle clock-enable pulse to the processor.
running  output  1  1 while in RUN state.
display_data  output  DATA_W  captured `result_in`, fed to the display driver.
step_count  output  16  number of `proc_en` pulses issued; wraps.

Behaviour:
- Reset (synchronous, while `reset`=1, takes effect at the clock edge):
  - state=HALT; `proc_en`=0, `running`=0, `display_data`=0, `step_count`=0.
  - Synchronizers, debounced levels, debounce counters and the tick counter are all cleared to 0.
  - Reset asserted mid-operation (any state, any counter value) gives these values on the next edge. No pulse is pending afterwards.
- Input conditioning, per button, identical and independent:
  - 2-flop synchronizer.
  - Debounce counter resets to 0 whenever the synchronized level equals the debounced level.
  - Otherwise it increments. When it reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A press is a rising edge of the debounced level, registered as a 1-cycle pulse: `run_p` or `step_p`.
  - Releases generate nothing.
  - Bounces shorter than DB_CYCLES are fully rejected.
- FSM, states HALT / RUN / STEP:
  - HALT:
    - `run_p` -> RUN, tick counter cleared.
    - else `step_p` -> STEP.
    - `run_p` and `step_p` in the same cycle: RUN wins, the step is dropped.
  - STEP: `proc_en`=1 for exactly this one cycle, then -> HALT unconditionally. Presses arriving in STEP are dropped.
  - RUN:
    - Tick counter, width $clog2(RUN_DIV), counts 0..RUN_DIV-1 and wraps to 0.
    - `proc_en`=1 in the cycle the counter equals RUN_DIV-1.
    - `run_p` -> HALT. If it coincides with the terminal count, that pulse is still issued and the transition happens on the same edge.
    - `step_p` is ignored in RUN.
- `proc_en`:
  - Decoded registered: high in STEP, or in RUN at terminal count.
  - First RUN pulse occurs RUN_DIV cycles after entering RUN.
  - Never high for two consecutive cycles.
- `running` = (state==RUN).
- Capture:
  - `en_d` = `proc_en` delayed by one cycle.
  - When `en_d`=1, `display_data` <= `result_in`. This gives the core one enable-cycle to update its result.
  - Capture is independent of the current state, so a pulse issued on a RUN->HALT edge is still captured.
  - Otherwise `display_data` holds.
- `step_count`: +1 on every cycle with `proc_en`=1; 16-bit unsigned, 0xFFFF -> 0x0000.
- End-to-end latency, stable press to `proc_en` in HALT: 2 synchronizer + DB_CYCLES debounce + 1 edge register + 1 FSM cycle, within ±1 cycle. The bench checks the pulse count, not exact arrival.

Test Plan:
(Bench params: RUN_DIV=4, DB_CYCLES=3, DATA_W=16.)
1. Hold `reset` for 3 cycles with both buttons high -> `proc_en`=0, `running`=0, `display_data`=0x0000, `step_count`=0. No pulse after reset release until a fresh press is debounced.
2. `btn_step` bounces 1,0,1,0 (1 cycle each), then stays high 12 cycles with `result_in`=0xBEEF -> exactly one `proc_en` pulse, `step_count`=1, `display_data`=0xBEEF one cycle after the pulse. Release then re-press -> `step_count`=2.
3. From HALT, press `btn_run` -> `running`=1; `proc_en` pulses every 4th cycle; 5 pulses in 20 cycles. `display_data` tracks `result_in` one cycle after each pulse. Pressing `btn_step` during RUN changes nothing.
4. In RUN, align the debounced `run_p` with terminal count -> that pulse is issued, `step_count` is incremented and the value captured; `running`=0 next cycle; no further pulses over 20 cycles.
5. In HALT, press `btn_run` and `btn_step` so both debounced edges land in the same cycle -> RUN entered; the first pulse comes 4 cycles later, not 1.
6. Assert `reset` in RUN with the tick counter at 2 and `step_count`=7 -> next cycle state=HALT, `step_count`=0, `display_data`=0; no `proc_en` for 10 cycles.
